mpmc11_burst_sequencer: RTL
===========================

Name: mpmc11_burst_sequencer

Overview:
Sequences one strip (burst) transaction between the mpmc11 channel front end and the DDR app interface.
- Accepts one request (address, direction, beat count).
- Write: pushes all write-data beats to the write-data FIFO, then issues one command per beat.
- Read: issues one command per beat and collects the same number of returned beats.
- Pulses done on completion. Sits between the mpmc11 channel arbiter and the MIG-style app port.

Parameters:
AWID, 32, app/request address width
DWID, 128, data beat width
ADR_INC, 16, byte address increment per beat

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request (IDLE only)
req_we  in  1  1=write, 0=read
req_adr  in  AWID  start byte address
req_len  in  6  beats minus one (0..63 gives 1..64 beats)
wdat_valid  in  1  write beat available
wdat_ready  out  1  write beat consumed this cycle
wdat  in  DWID  write beat data
rdat_valid  out  1  read beat valid
rdat  out  DWID  read beat data
rdat_last  out  1  final read beat
done  out  1  one-cycle completion pulse
state  out  mpmc11_seq_state_t  current state (observability)
app_en  out  1  command valid
app_cmd  out  3  CMD_WRITE / CMD_READ
app_addr  out  AWID  command address
app_rdy  in  1  command accepted when app_en&&app_rdy
app_wdf_wren  out  1  write-data valid
app_wdf_end  out  1  equals app_wdf_wren (one beat per burst)
app_wdf_data  out  DWID  equals wdat
app_wdf_rdy  in  1  write FIFO ready
app_rd_data  in  DWID  returned read data
app_rd_data_valid  in  1  returned read data valid

Behaviour:
- Reset (any cycle, including mid-transaction):
  - state=IDLE; all control outputs 0 (req_ready=1 in IDLE); both counters 0; latched address 0.
  - A partially issued burst is abandoned; there is no recovery.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_we, req_adr, req_len into len_r; go to PRESET.
  - req_ready is 0 in every other state.
- PRESET: one cycle; clear cmd_cnt and dat_cnt (7-bit each); go to WRITE_DATA if we_r, else READ_CMD.
- WRITE_DATA:
  - app_wdf_wren = wdat_valid.
  - wdat_ready = wdat_valid && app_wdf_rdy. A beat transfers only when both are 1.
  - dat_cnt increments per transfer. When the transferring beat has dat_cnt==len_r, go to WRITE_CMD next cycle.
- WRITE_CMD:
  - app_en=1, app_cmd=CMD_WRITE, app_addr = adr_r + cmd_cnt*ADR_INC (modulo 2^AWID).
  - cmd_cnt increments on app_rdy. On acceptance with cmd_cnt==len_r, go to DONE.
  - app_en is held and app_addr is stable while app_rdy=0.
- READ_CMD:
  - Same command rule with CMD_READ.
  - On the last command acceptance: go to DONE if dat_cnt already reached len_r+1, otherwise go to READ_DATA.
- Read return (in READ_CMD and READ_DATA):
  - rdat_valid = app_rd_data_valid and rdat = app_rd_data, combinational pass-through, zero latency.
  - dat_cnt increments per valid beat. rdat_last=1 on the beat with dat_cnt==len_r.
  - In READ_DATA, the rdat_last beat moves to DONE.
  - app_rd_data_valid in any other state is ignored: no rdat_valid, no count.
- Simultaneous last read beat and last command accept in READ_CMD: go to DONE directly.
- DONE: done=1 for one cycle; go to IDLE. A new request is accepted no earlier than the cycle after DONE.
- req_len=0: exactly one data beat and one command.
- req_len=63: 64 of each. The 7-bit counters never wrap.
- Address wraps modulo 2^AWID with no error.

Decomposition:
- mpmc11_pkg gains:
  - mpmc11_seq_state_t enum {IDLE, PRESET, WRITE_DATA, WRITE_CMD, READ_CMD, READ_DATA, DONE}.
  - CMD_WRITE = 3'b000, CMD_READ = 3'b001.
- Sub-module mpmc11_beat_counter (clr, inc, len, cnt, last = inc && cnt==len), instantiated twice: command count and data count.

Test Plan:
- Write, req_adr=0x1000, req_len=3, wdat_valid/app_wdf_rdy/app_rdy always 1 -> 4 wdf beats, then 4 commands at 0x1000/0x1010/0x1020/0x1030; done pulses once; req_ready returns next cycle.
- Read, req_len=7, app_rdy toggling 1/0 -> 8 commands with app_addr stable while stalled; rd_data_valid beats 8 pass through; rdat_last on the 8th; done once.
- Read where all data returns during READ_CMD, with the last beat coinciding with the last accept -> state goes READ_CMD to DONE directly, skipping READ_DATA.
- Write, req_len=0, app_wdf_rdy low for 5 cycles -> wdat_ready stays 0 for those cycles; exactly one beat and one command; app_wdf_end=app_wdf_wren.
- req_adr=0xFFFFFFF0, req_len=1, write -> command addresses 0xFFFFFFF0 then 0x00000000.
- rst asserted in READ_CMD after 2 of 8 commands -> next cycle state=IDLE, app_en=0, req_ready=1; stray app_rd_data_valid produces no rdat_valid.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared types and constants for the mpmc11 burst sequencer
//   mpmc11_seq_state_t : sequencer FSM states
//   CMD_WRITE/CMD_READ : MIG-style app command encodings
//   CNT_W              : beat counter width (counts 0..64 without wrapping)
package mpmc11_pkg;
   typedef enum logic [2:0] {
      IDLE,
      PRESET,
      WRITE_DATA,
      WRITE_CMD,
      READ_CMD,
      READ_DATA,
      DONE
   } mpmc11_seq_state_t;
   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;
   localparam int CNT_W = 7;
endpackage

// File: rtl/mpmc11_beat_counter.sv
// mpmc11_beat_counter: beat counter with terminal-beat detect
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear
//   inc_i    : count one beat
//   len_i    : beats minus one
//   cnt_o    : beats counted so far
//   last_o   : the beat counted this cycle is the final one
module mpmc11_beat_counter
   import mpmc11_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-2:0] len_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             last_o
);
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk)
      if (rst || clr_i) cnt_q <= '0;
      else if (inc_i) cnt_q <= cnt_q + 1'b1;
   assign cnt_o  = cnt_q;
   assign last_o = inc_i && cnt_q == {1'b0, len_i};
endmodule

// File: rtl/mpmc11_burst_sequencer.sv
// mpmc11_burst_sequencer: runs one burst between the channel front end and the DDR app port
//   req_*   : request handshake (address, direction, beats minus one)
//   wdat_*  : write beats from the front end
//   rdat_*  : read beats to the front end (pass-through of app_rd_data)
//   done    : one-cycle completion pulse; state exposes the FSM
//   app_*   : MIG-style command, write-data and read-return ports
module mpmc11_burst_sequencer
   import mpmc11_pkg::*;
#(
   parameter int AWID    = 32,
   parameter int DWID    = 128,
   parameter int ADR_INC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AWID-1:0]   req_adr,
   input  logic [5:0]        req_len,
   input  logic              wdat_valid,
   output logic              wdat_ready,
   input  logic [DWID-1:0]   wdat,
   output logic              rdat_valid,
   output logic [DWID-1:0]   rdat,
   output logic              rdat_last,
   output logic              done,
   output mpmc11_seq_state_t state,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [AWID-1:0]   app_addr,
   input  logic              app_rdy,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   output logic [DWID-1:0]   app_wdf_data,
   input  logic              app_wdf_rdy,
   input  logic [DWID-1:0]   app_rd_data,
   input  logic              app_rd_data_valid
);
   mpmc11_seq_state_t state_q;
   logic              we_q;
   logic [AWID-1:0]   adr_q;
   logic [5:0]        len_q;
   logic [CNT_W-1:0]  cmd_cnt, dat_cnt;
   logic              cmd_inc, dat_inc, cmd_last, dat_last, rd_st, cmd_st;
   assign rd_st   = state_q == READ_CMD || state_q == READ_DATA;
   assign cmd_st  = state_q == WRITE_CMD || state_q == READ_CMD;
   assign cmd_inc = cmd_st && app_rdy;
   // read returns outside the read states are dropped, never counted
   assign dat_inc = (state_q == WRITE_DATA && wdat_valid && app_wdf_rdy) || (rd_st && app_rd_data_valid);
   mpmc11_beat_counter u_cmd_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (state_q == PRESET),
      .inc_i  (cmd_inc),
      .len_i  (len_q),
      .cnt_o  (cmd_cnt),
      .last_o (cmd_last)
   );
   mpmc11_beat_counter u_dat_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (state_q == PRESET),
      .inc_i  (dat_inc),
      .len_i  (len_q),
      .cnt_o  (dat_cnt),
      .last_o (dat_last)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         adr_q   <= '0;
         len_q   <= '0;
      end else begin
         case (state_q)
            IDLE:
               if (req_valid) begin
                  we_q    <= req_we;
                  adr_q   <= req_adr;
                  len_q   <= req_len;
                  state_q <= PRESET;
               end
            PRESET:     state_q <= we_q ? WRITE_DATA : READ_CMD;
            WRITE_DATA: if (dat_last) state_q <= WRITE_CMD;
            WRITE_CMD:  if (cmd_last) state_q <= DONE;
            // all data may already be back (or arrive with the last accept)
            READ_CMD:
               if (cmd_last)
                  state_q <= (dat_last || dat_cnt == {1'b0, len_q} + 1'b1) ? DONE : READ_DATA;
            READ_DATA:  if (dat_last) state_q <= DONE;
            DONE:       state_q <= IDLE;
            default:    state_q <= IDLE;
         endcase
      end
   assign state        = state_q;
   assign req_ready    = state_q == IDLE;
   assign done         = state_q == DONE;
   assign app_en       = cmd_st;
   assign app_cmd      = state_q == READ_CMD ? CMD_READ : CMD_WRITE;
   assign app_addr     = adr_q + AWID'(cmd_cnt) * AWID'(ADR_INC);
   assign app_wdf_wren = state_q == WRITE_DATA && wdat_valid;
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_data = wdat;
   assign wdat_ready   = app_wdf_wren && app_wdf_rdy;
   assign rdat_valid   = rd_st && app_rd_data_valid;
   assign rdat         = app_rd_data;
   assign rdat_last    = rd_st && dat_last;
endmodule
